mfp_mac_par: RTL and testbench

// - Parallel fixed-point multiply-accumulate: dot product of ArrL samples with ArrL coefficients in one pass.
// - Produces one rounded result per enabled clock.
// - Serves as the 1-D Gaussian filter tap engine in the SIFT pipeline.
// - Input: a vertical pixel column from the line-buffer window. Output: feeds the DoG stage.

---
 rtl/mfp_mac_par.sv | 150 +++++++++++++++
 tb/tb_mfp_mac_par.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mfp_mac_par.sv
// Pipelined fixed-point dot product: ArrL samples times ArrL coefficients.
// Define MFP_MAC_SAT_EN to saturate the result; otherwise it wraps.
module mfp_mac_par #(
  parameter int In1W         = 8,
  parameter int In2W         = 6,
  parameter int In2EQW       = 8,
  parameter int ArrL         = 19,
  parameter int PordW_ROUND  = 9,
  parameter int AccW_ROUND   = 8,
  parameter int pipeInterval = 3,
  parameter int isUnsigned   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [In1W*ArrL-1:0]     In1,
  input  logic [In2W*ArrL-1:0]     In2,
  output logic [AccW_ROUND-1:0]    Out
);

  localparam int F  = PordW_ROUND - In1W;
  localparam int RS = In2EQW - F;
  localparam int PW = In1W + In2W;
  localparam int NL = $clog2(ArrL);
  localparam int AW = PordW_ROUND + NL;
  localparam int QW = AW + 1 - F;
  localparam int TW = (PW + 1 > RS + PordW_ROUND) ?
                      PW + 1 : RS + PordW_ROUND;
  localparam logic SG = (isUnsigned == 0);

  localparam logic [TW-1:0] PRC = (TW'(1) << RS) >> 1;
  localparam logic [AW:0]   ORC = ((AW + 1)'(1) << F) >> 1;

  function automatic int cntAt(input int l);
    int n;
    n = ArrL;
    for (int k = 0; k < l; k++) n = (n + 1) / 2;
    return n;
  endfunction

  logic [PW-1:0] mulC [ArrL];
  logic [PW-1:0] prod [ArrL];

  always_comb begin
    for (int i = 0; i < ArrL; i++) begin
      logic [In1W-1:0] a;
      logic [In2W-1:0] b;
      logic [PW-1:0]   ax;
      logic [PW-1:0]   bx;
      a  = In1[i*In1W +: In1W];
      b  = In2[i*In2W +: In2W];
      ax = {{In2W{SG & a[In1W-1]}}, a};
      bx = {{In1W{SG & b[In2W-1]}}, b};
      mulC[i] = ax * bx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ArrL; i++) prod[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < ArrL; i++) prod[i] <= mulC[i];
    end
  end

  for (genvar l = 0; l <= NL; l++) begin : lvl
    localparam int NC = cntAt(l);
    logic [AW-1:0] v [NC];

    if (l == 0) begin : g0
      // round half up at the product, keeping F fraction bits
      always_comb begin
        for (int i = 0; i < ArrL; i++) begin
          logic [TW-1:0]          t;
          logic [PordW_ROUND-1:0] r;
          t = {{(TW-PW){SG & prod[i][PW-1]}}, prod[i]};
          r = PordW_ROUND'((t + PRC) >> RS);
          v[i] = {{(AW-PordW_ROUND){SG & r[PordW_ROUND-1]}}, r};
        end
      end
    end else begin : gn
      localparam int NP = cntAt(l - 1);
      logic [AW-1:0] s [NC];

      for (genvar j = 0; j < NC; j++) begin : e
        if (2 * j + 1 < NP) begin : pair
          assign s[j] = lvl[l-1].v[2*j] + lvl[l-1].v[2*j+1];
        end else begin : pass
          assign s[j] = lvl[l-1].v[2*j];
        end
      end

      if ((l % pipeInterval) == 0 || l == NL) begin : gr
        always_ff @(posedge clk) begin
          if (rst) begin
            for (int j = 0; j < NC; j++) v[j] <= '0;
          end else if (en) begin
            for (int j = 0; j < NC; j++) v[j] <= s[j];
          end
        end
      end else begin : gc
        always_comb begin
          for (int j = 0; j < NC; j++) v[j] = s[j];
        end
      end
    end
  end

  logic [AW-1:0]         acc;
  logic [AW:0]           accX;
  logic [AccW_ROUND-1:0] res;

  assign acc  = lvl[NL].v[0];
  assign accX = {SG & acc[AW-1], acc};

`ifdef MFP_MAC_SAT_EN
  logic [QW-1:0] q;
  logic          fits;

  always_comb begin
    q = QW'((accX + ORC) >> F);
    if (SG) begin
      fits = (&q[QW-1:AccW_ROUND-1]) | ~(|q[QW-1:AccW_ROUND-1]);
    end else begin
      fits = ~(|q[QW-1:AccW_ROUND]);
    end
    res = q[AccW_ROUND-1:0];
    if (!fits) begin
      if (!SG) begin
        res = '1;
      end else if (q[QW-1]) begin
        res = {1'b1, {(AccW_ROUND-1){1'b0}}};
      end else begin
        res = {1'b0, {(AccW_ROUND-1){1'b1}}};
      end
    end
  end
`else
  assign res = AccW_ROUND'((accX + ORC) >> F);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      Out <= '0;
    end else if (en) begin
      Out <= res;
    end
  end

endmodule

// File: tb/tb_mfp_mac_par.sv
// Directed bench for mfp_mac_par at default parameters.
// Expected values are hand-computed dot products.
module tb_mfp_mac_par;

  localparam int In1W = 8;
  localparam int In2W = 6;
  localparam int ArrL = 19;
  localparam int AccW = 8;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic [In1W*ArrL-1:0] in1;
  logic [In2W*ArrL-1:0] in2;
  logic [AccW-1:0]      out;

  int checks;
  int errs;

  mfp_mac_par dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .In1 (in1),
    .In2 (in2),
    .Out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic e);
    en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic fillAll(input logic [7:0] a, input logic [5:0] b);
    for (int i = 0; i < ArrL; i++) begin
      in1[i*In1W +: In1W] = a;
      in2[i*In2W +: In2W] = b;
    end
  endtask

  task automatic applyVec(input int k);
    in1 = '0;
    in2 = '0;
    case (k)
      0: begin
        in1[9*In1W +: In1W] = 8'd200;
        in2[9*In2W +: In2W] = 6'd32;
      end
      1: fillAll(8'd128, 6'd13);
      2: begin
        in1[0 +: In1W] = 8'd2;
        in2[0 +: In2W] = 6'd32;
      end
      3: fillAll(8'd255, 6'd63);
      5: begin
        in1[0 +: In1W] = 8'd1;
        in2[0 +: In2W] = 6'd63;
      end
      default: ;
    endcase
  endtask

  function automatic int expVal(input int k);
    case (k)
      0: return 25;
`ifdef MFP_MAC_SAT_EN
      3: return 255;
`else
      3: return 173;
`endif
      1: return 124;
      2: return 1;
      default: return 0;
    endcase
  endfunction

  initial begin
    int hist[$];
    int cur;
    int vk;
    logic e;

    checks = 0;
    errs   = 0;
    rst = 1'b1;
    en  = 1'b1;
    applyVec(3);

    repeat (3) begin
      step(1'b1);
      chk("rstHold", int'(out), 0);
    end
    rst = 1'b0;
    applyVec(4);
    repeat (5) begin
      step(1'b1);
      chk("zeroRun", int'(out), 0);
    end

    applyVec(0);
    step(1'b1);
    chk("lat0", int'(out), 0);
    applyVec(4);
    step(1'b1);
    chk("lat1", int'(out), 0);
    step(1'b1);
    chk("lat2", int'(out), 0);
    step(1'b1);
    chk("singleTap", int'(out), 25);
    step(1'b1);
    chk("singleGone", int'(out), 0);

    for (int k = 1; k <= 5; k++) begin
      if (k != 4) begin
        applyVec(k);
        repeat (4) step(1'b1);
        chk($sformatf("vec%0d", k), int'(out), expVal(k));
      end
    end

    hist = '{0, 0, 0};
    cur  = 0;
    vk   = 0;
    for (int n = 0; n < 16; n++) begin
      e = (n % 4 == 0) || (n % 4 == 3);
      if (e) begin
        applyVec(vk % 4);
        hist.push_back(expVal(vk % 4));
        vk++;
      end else begin
        applyVec((vk + 1) % 4);
      end
      step(e);
      if (e) cur = hist[hist.size()-4];
      chk($sformatf("stall%0d", n), int'(out), cur);
    end
    applyVec(4);
    for (int n = 0; n < 3; n++) begin
      hist.push_back(0);
      step(1'b1);
      chk($sformatf("drain%0d", n), int'(out), hist[hist.size()-4]);
    end

    applyVec(3);
    repeat (4) step(1'b1);
    chk("ovfPre", int'(out), expVal(3));
    rst = 1'b1;
    step(1'b1);
    chk("rstMid", int'(out), 0);
    rst = 1'b0;
    applyVec(1);
    step(1'b1);
    chk("post0", int'(out), 0);
    applyVec(4);
    step(1'b1);
    chk("post1", int'(out), 0);
    step(1'b1);
    chk("post2", int'(out), 0);
    step(1'b1);
    chk("post3", int'(out), 124);

    applyVec(3);
    repeat (4) step(1'b1);
    rst = 1'b1;
    step(1'b0);
    chk("rstOverEn", int'(out), 0);
    rst = 1'b0;
    step(1'b1);
    chk("rstFlushed", int'(out), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
